// File: rtl/imem_loader.sv
// Framed byte-stream loader: fills instruction memory over valid/ready,
// verifies an 8-bit checksum and holds the pipeline in reset until a good frame.
module imem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       R,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_R,
    output logic       done,
    output logic       error,
    output logic [8:0] byte_count
);

    localparam int unsigned AW = 8;
    localparam int unsigned CW = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          cpu_r_q, cpu_r_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          accept;
    logic [7:0]    sum_next;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= IDLE;
            rem_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cpu_r_q <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cpu_r_q <= cpu_r_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state and datapath decode; in_ready depends on the state only
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        count_d  = count_q;
        sum_d    = sum_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        cpu_r_d  = cpu_r_q;
        done_d   = done_q;
        error_d  = error_q;
        in_ready = 1'b0;
        sum_next = 8'(sum_q + in_data);

        case (state_q)
            IDLE: state_d = SYNC;
            SYNC: in_ready = 1'b1;
            LEN:  in_ready = 1'b1;
            DATA: in_ready = 1'b1;
            CHK:  in_ready = 1'b1;
            ERR:  state_d = SYNC;
            default: ;
        endcase

        accept = in_valid && in_ready;

        if (accept) begin
            case (state_q)
                SYNC: begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    // LEN of zero encodes a full 256-byte frame
                    rem_d   = (in_data == 8'h00) ? CW'(256) : CW'(in_data);
                    count_d = '0;
                    sum_d   = '0;
                    ptr_d   = BASE_ADDR;
                    state_d = DATA;
                end
                DATA: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = in_data;
                    sum_d   = sum_next;
                    ptr_d   = AW'(ptr_q + AW'(1));
                    count_d = CW'(count_q + CW'(1));
                    rem_d   = CW'(rem_q - CW'(1));
                    if (rem_q == CW'(1)) begin
                        state_d = CHK;
                    end
                end
                CHK: begin
                    sum_d = sum_next;
                    if (sum_next == 8'h00) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cpu_r_d = 1'b0;
                        error_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign cpu_R      = cpu_r_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle vector table plus framed-byte sequences.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       r1, r2;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy1, we1, cpu1, done1, err1;
    logic [7:0] addr1, data1;
    logic [8:0] bc1;
    logic       rdy2, we2, cpu2, done2, err2;
    logic [7:0] addr2, data2;
    logic [8:0] bc2;

    logic       sel2;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [7:0] wa1[$], wd1[$], wa2[$], wd2[$];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5)) u_dut1 (
        .clk(clk), .R(r1), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_data(data1),
        .cpu_R(cpu1), .done(done1), .error(err1), .byte_count(bc1)
    );

    imem_loader #(.BASE_ADDR(8'h10), .SYNC_BYTE(8'hA5)) u_dut2 (
        .clk(clk), .R(r2), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy2), .mem_we(we2), .mem_addr(addr2), .mem_data(data2),
        .cpu_R(cpu2), .done(done2), .error(err2), .byte_count(bc2)
    );

    // Write logger, sampled mid-cycle
    always @(negedge clk) begin
        if (we1) begin wa1.push_back(addr1); wd1.push_back(data1); end
        if (we2) begin wa2.push_back(addr2); wd2.push_back(data2); end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset1();
        r1 = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 r1 = 1'b0;
        wa1.delete(); wd1.delete();
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = b;
        for (int i = 0; i < 20; i++) begin
            rdy = sel2 ? rdy2 : rdy1;
            @(posedge clk);
            #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted", b);
        end
    endtask

    task automatic check_log1(input string name, input int n,
                              input logic [7:0] a0, input logic [7:0] d0,
                              input logic [7:0] a1, input logic [7:0] d1,
                              input logic [7:0] a2, input logic [7:0] d2);
        logic [7:0] ea[3];
        logic [7:0] ed[3];
        int bad;
        ea[0] = a0; ea[1] = a1; ea[2] = a2;
        ed[0] = d0; ed[1] = d1; ed[2] = d2;
        check({name, "_nwrites"}, 32'(wa1.size()), 32'(n));
        bad = 0;
        for (int i = 0; i < n && i < wa1.size(); i++)
            if (wa1[i] !== ea[i] || wd1[i] !== ed[i]) bad++;
        check({name, "_wdata"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       cpu_r;
        logic       done;
        logic       err;
        logic [8:0] bc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        sel2 = 1'b0; r1 = 1'b1; r2 = 1'b1; in_valid = 1'b0; in_data = 8'h00;

        // Good frame A5 03 11 22 33 9A, one row per clock
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0};
        vecs[4] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 9'd1};
        vecs[5] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h01, 8'h22, 1'b1, 1'b0, 1'b0, 9'd2};
        vecs[6] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h02, 8'h33, 1'b1, 1'b0, 1'b0, 9'd3};
        vecs[7] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 8'h02, 8'h33, 1'b0, 1'b1, 1'b0, 9'd3};
        vecs[8] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h02, 8'h33, 1'b0, 1'b1, 1'b0, 9'd3};

        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            r1 = vecs[i].r; in_valid = vecs[i].v; in_data = vecs[i].d;
            @(posedge clk); #1;
            check($sformatf("vec%0d_in_ready", i), 32'(rdy1), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_mem_we", i), 32'(we1), 32'(vecs[i].we));
            check($sformatf("vec%0d_mem_addr", i), 32'(addr1), 32'(vecs[i].addr));
            check($sformatf("vec%0d_mem_data", i), 32'(data1), 32'(vecs[i].data));
            check($sformatf("vec%0d_cpu_R", i), 32'(cpu1), 32'(vecs[i].cpu_r));
            check($sformatf("vec%0d_done", i), 32'(done1), 32'(vecs[i].done));
            check($sformatf("vec%0d_error", i), 32'(err1), 32'(vecs[i].err));
            check($sformatf("vec%0d_byte_count", i), 32'(bc1), 32'(vecs[i].bc));
        end
        in_valid = 1'b0;

        // Bad checksum, then a good frame clears the error
        reset1();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        check("bad_error", 32'(err1), 32'd1);
        check("bad_cpu_R", 32'(cpu1), 32'd1);
        check("bad_done", 32'(done1), 32'd0);
        check("bad_err_ready", 32'(rdy1), 32'd0);
        check_log1("bad", 2, 8'h00, 8'h10, 8'h01, 8'h20, 8'h00, 8'h00);
        @(posedge clk); #1;
        check("bad_resync_ready", 32'(rdy1), 32'd1);
        check("bad_error_sticky", 32'(err1), 32'd1);
        wa1.delete(); wd1.delete();
        send(8'hA5); send(8'h01); send(8'h7F); send(8'h81);
        check("retry_done", 32'(done1), 32'd1);
        check("retry_error", 32'(err1), 32'd0);
        check("retry_cpu_R", 32'(cpu1), 32'd0);
        check_log1("retry", 1, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00);

        // Junk before sync is discarded
        reset1();
        send(8'h00); send(8'hFF); send(8'h5A);
        check("junk_nowrite", 32'(wa1.size()), 32'd0);
        send(8'hA5); send(8'h01); send(8'h01); send(8'hFF);
        check("junk_done", 32'(done1), 32'd1);
        check_log1("junk", 1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);

        // Handshake gaps give identical writes
        reset1();
        begin
            logic [7:0] fr[6];
            fr[0] = 8'hA5; fr[1] = 8'h03; fr[2] = 8'h11;
            fr[3] = 8'h22; fr[4] = 8'h33; fr[5] = 8'h9A;
            for (int i = 0; i < 6; i++) begin
                in_data = 8'hA5;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(fr[i]);
            end
        end
        repeat (2) @(posedge clk); #1;
        check("gap_done", 32'(done1), 32'd1);
        check("gap_bc", 32'(bc1), 32'd3);
        check_log1("gap", 3, 8'h00, 8'h11, 8'h01, 8'h22, 8'h02, 8'h33);

        // Reset mid-DATA: reset wins over a simultaneous handshake
        reset1();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
        r1 = 1'b1; in_valid = 1'b1; in_data = 8'h33;
        @(posedge clk); #1;
        r1 = 1'b0; in_valid = 1'b0;
        check("midrst_ready", 32'(rdy1), 32'd0);
        check("midrst_bc", 32'(bc1), 32'd0);
        check("midrst_cpu_R", 32'(cpu1), 32'd1);
        check("midrst_we", 32'(we1), 32'd0);
        check_log1("midrst", 2, 8'h00, 8'h11, 8'h01, 8'h22, 8'h00, 8'h00);
        wa1.delete(); wd1.delete();
        send(8'hA5); send(8'h03); send(8'h44); send(8'h55); send(8'h66); send(8'h01);
        check("midrst_reload_done", 32'(done1), 32'd1);
        check_log1("midrst_reload", 3, 8'h00, 8'h44, 8'h01, 8'h55, 8'h02, 8'h66);

        // LEN=0 frame with BASE_ADDR=0x10 wraps the address pointer
        r1 = 1'b1; sel2 = 1'b1;
        @(posedge clk); #1;
        r2 = 1'b0; wa2.delete(); wd2.delete();
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        check("wrap_bc", 32'(bc2), 32'd256);
        send(8'h80);
        check("wrap_done", 32'(done2), 32'd1);
        check("wrap_cpu_R", 32'(cpu2), 32'd0);
        check("wrap_nwrites", 32'(wa2.size()), 32'd256);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256 && i < wa2.size(); i++)
                if (wa2[i] !== 8'(i + 16) || wd2[i] !== 8'(i)) bad++;
            check("wrap_wdata", 32'(bad), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
